ahb_block_bridge: RTL

Parametrised AHB-Lite slave front end for the AES accelerator: it packs 32-bit host writes into BLOCK_W-bit blocks queued in a TX FIFO for the cipher engine, and unpacks engine result blocks from an RX FIFO into 32-bit host reads. It generalises the fixed 128-bit AHB/FIFO interface with configurable block width and FIFO depths, live occupancy counts, sticky error flags, flush, and defined AHB ERROR responses. It sits between the AHB bus and the encrypt/decrypt datapath.

---
 rtl/ahb_block_bridge.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_block_bridge.sv
// AHB-Lite slave that packs 32-bit host writes into BLOCK_W-bit blocks for the cipher
// engine (TX FIFO) and unpacks engine result blocks into 32-bit host reads (RX FIFO).
`timescale 1ns/1ps
module ahb_block_bridge #(
  parameter int BLOCK_W  = 128,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSELx,
  input  logic               HWRITE,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic [2:0]         HSIZE,
  input  logic [1:0]         HTRANS,
  output logic [31:0]        HRDATA,
  output logic               HREADY,
  output logic [1:0]         HRESP,
  output logic [BLOCK_W-1:0] in_block,
  output logic               in_valid,
  input  logic               in_ready,
  input  logic [BLOCK_W-1:0] out_block,
  input  logic               out_valid,
  output logic               out_ready,
  output logic               mode
);
  localparam int NW  = BLOCK_W / 32;
  localparam int IW  = $clog2(NW);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam logic [IW-1:0]  LAST_IDX    = IW'(NW - 1);
  localparam logic [TPW-1:0] TX_LAST     = TPW'(TX_DEPTH - 1);
  localparam logic [RPW-1:0] RX_LAST     = RPW'(RX_DEPTH - 1);
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  logic           dp_valid_q, dp_write_q, dp_bad_q, err2_q;
  logic [1:0]     dp_addr_q;
  logic [IW-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic           ovf_q, ovf_d, udf_q, udf_d, mode_q, mode_d;
  logic [TPW-1:0] tx_wp_q, tx_rp_q;
  logic [RPW-1:0] rx_wp_q, rx_rp_q;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;

  logic [31:0]        asm_q  [NW];
  logic [BLOCK_W-1:0] tx_mem [TX_DEPTH];
  logic [BLOCK_W-1:0] rx_mem [RX_DEPTH];

  logic               capture, bad_req, err_now, flush;
  logic               tx_push, tx_pop, rx_push, rx_pop, asm_we;
  logic               hready, hresp;
  logic [31:0]        hrdata, status;
  logic               tx_full, tx_empty, rx_full, rx_empty;
  logic [BLOCK_W-1:0] tx_block, rx_head;
  logic [31:0]        rx_words [NW];
  logic               unused_ok;

  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign status   = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b00, udf_q, ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};

  // Completing word goes straight from HWDATA into the top of the pushed block.
  assign rx_head = rx_mem[rx_rp_q];
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_words
      assign rx_words[gi] = rx_head[gi*32 +: 32];
      if (gi < NW - 1) begin : g_asm
        assign tx_block[gi*32 +: 32] = asm_q[gi];
      end else begin : g_last
        assign tx_block[gi*32 +: 32] = HWDATA;
      end
    end
  endgenerate

  assign capture = HSELx & HTRANS[1] & hready;
  assign bad_req = (HSIZE != 3'b010) |
                   (HWRITE ? (HADDR[3:2] == 2'd1 || HADDR[3:2] == 2'd2)
                           : (HADDR[3:2] == 2'd0));

  always_comb begin
    hready   = 1'b1;
    hresp    = 1'b0;
    hrdata   = '0;
    err_now  = 1'b0;
    flush    = 1'b0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    asm_we   = 1'b0;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    mode_d   = mode_q;
    if (err2_q) begin
      hresp = 1'b1;
    end else if (dp_valid_q) begin
      if (dp_bad_q) begin
        err_now = 1'b1;
      end else begin
        case (dp_addr_q)
          2'd0: begin
            if (wr_idx_q != LAST_IDX) begin
              asm_we   = 1'b1;
              wr_idx_d = wr_idx_q + 1'b1;
            end else if (tx_full) begin
              err_now = 1'b1;
              ovf_d   = 1'b1;
            end else begin
              tx_push  = 1'b1;
              wr_idx_d = '0;
            end
          end
          2'd1: begin
            if (rx_empty) begin
              err_now = 1'b1;
              udf_d   = 1'b1;
            end else begin
              hrdata = rx_words[rd_idx_q];
              if (rd_idx_q == LAST_IDX) begin
                rx_pop   = 1'b1;
                rd_idx_d = '0;
              end else begin
                rd_idx_d = rd_idx_q + 1'b1;
              end
            end
          end
          2'd2: hrdata = status;
          default: begin
            if (dp_write_q) begin
              mode_d = HWDATA[0];
              if (HWDATA[1]) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
              end
              if (HWDATA[2]) begin
                flush    = 1'b1;
                wr_idx_d = '0;
                rd_idx_d = '0;
              end
            end else begin
              hrdata = {31'b0, mode_q};
            end
          end
        endcase
      end
      if (err_now) begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
    end
  end

  // A flush overrides any engine handshake in the same cycle.
  assign tx_pop  = in_valid & in_ready & ~flush;
  assign rx_push = out_valid & out_ready & ~flush;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_push & ~tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
    if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    if (rx_push & ~rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
    if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_bad_q   <= 1'b0;
      dp_addr_q  <= '0;
      err2_q     <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      mode_q     <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      dp_valid_q <= capture;
      dp_write_q <= HWRITE;
      dp_bad_q   <= bad_req;
      dp_addr_q  <= HADDR[3:2];
      err2_q     <= err_now;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      mode_q     <= mode_d;
      if (flush) begin
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        tx_cnt_q <= '0;
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (tx_push) tx_wp_q <= (tx_wp_q == TX_LAST) ? '0 : tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_q <= (tx_rp_q == TX_LAST) ? '0 : tx_rp_q + 1'b1;
        if (rx_push) rx_wp_q <= (rx_wp_q == RX_LAST) ? '0 : rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_q <= (rx_rp_q == RX_LAST) ? '0 : rx_rp_q + 1'b1;
        tx_cnt_q <= tx_cnt_d;
        rx_cnt_q <= rx_cnt_d;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (asm_we)  asm_q[wr_idx_q]  <= HWDATA;
    if (tx_push) tx_mem[tx_wp_q] <= tx_block;
    if (rx_push) rx_mem[rx_wp_q] <= out_block;
  end

  assign HRDATA    = hrdata;
  assign HREADY    = hready;
  assign HRESP     = {1'b0, hresp};
  assign in_valid  = ~tx_empty;
  assign in_block  = in_valid ? tx_mem[tx_rp_q] : '0;
  assign out_ready = ~rx_full;
  assign mode      = mode_q;
endmodule
